// File: rtl/adam_host_byte_bridge_if.sv
// Signal bundle between the host byte link, the bridge and ADAM's hsdom
// stream ports. The bridge connects through the slave modport; the
// environment that drives the host and ADAM sides uses the master modport.
interface adam_host_byte_bridge_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32
);
  localparam int FILL_W = $clog2(DIN_WIDTH / 8) + 1;

  // RX host byte stream and packed word toward ADAM
  logic [7:0]            rx_byte_i;
  logic                  rx_valid_i;
  logic                  rx_ready_o;
  logic                  rx_flush_i;
  logic [DIN_WIDTH-1:0]  hsdom_din_o;
  logic                  hsdom_din_valid_o;
  logic                  hsdom_din_ready_i;
  logic [FILL_W-1:0]     rx_fill_o;

  // TX word from ADAM and host byte stream
  logic [DOUT_WIDTH-1:0] hsdom_dout_i;
  logic                  hsdom_dout_valid_i;
  logic                  hsdom_dout_ready_o;
  logic [7:0]            tx_byte_o;
  logic                  tx_valid_o;
  logic                  tx_ready_i;

  modport slave (
    input  rx_byte_i, rx_valid_i, rx_flush_i, hsdom_din_ready_i,
    input  hsdom_dout_i, hsdom_dout_valid_i, tx_ready_i,
    output rx_ready_o, hsdom_din_o, hsdom_din_valid_o, rx_fill_o,
    output hsdom_dout_ready_o, tx_byte_o, tx_valid_o
  );

  modport master (
    output rx_byte_i, rx_valid_i, rx_flush_i, hsdom_din_ready_i,
    output hsdom_dout_i, hsdom_dout_valid_i, tx_ready_i,
    input  rx_ready_o, hsdom_din_o, hsdom_din_valid_o, rx_fill_o,
    input  hsdom_dout_ready_o, tx_byte_o, tx_valid_o
  );
endinterface

// File: rtl/adam_host_byte_bridge.sv
// Byte-serial host link adapter for ADAM's hsdom streams.
// RX packs host bytes little-endian into DIN_WIDTH words (with a flush that
// zero-pads a partial word); TX unpacks DOUT_WIDTH words into host bytes.
// The two paths share nothing but the clock and reset.
module adam_host_byte_bridge #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  adam_host_byte_bridge_if.slave  bus
);
  localparam int NI     = DIN_WIDTH / 8;
  localparam int NO     = DOUT_WIDTH / 8;
  localparam int FILL_W = $clog2(NI) + 1;
  localparam int IDX_W  = (NO > 1) ? $clog2(NO) : 1;

  typedef enum logic {RX_COLLECT = 1'b0, RX_HOLD = 1'b1} rx_state_e;
  typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

  // ---------------------------------------------------------------- RX path
  rx_state_e             rx_state_q, rx_state_d;
  logic [DIN_WIDTH-1:0]  asm_q, asm_d;
  logic [DIN_WIDTH-1:0]  asm_wr;
  logic [DIN_WIDTH-1:0]  din_q, din_d;
  logic                  din_valid_q, din_valid_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  rx_ready;
  logic                  rx_xfer;
  logic                  din_xfer;
  logic                  rx_last;

  // Assembly register with the incoming byte merged at the current fill slot
  always_comb begin
    asm_wr = asm_q;
    for (int k = 0; k < NI; k++) begin
      asm_wr[8*k +: 8] = (fill_q == FILL_W'(k)) ? bus.rx_byte_i : asm_q[8*k +: 8];
    end
  end

  // RX next state: byte collection, word emission on fill or flush, hold until ADAM takes it
  always_comb begin
    rx_state_d  = rx_state_q;
    asm_d       = asm_q;
    din_d       = din_q;
    din_valid_d = din_valid_q;
    fill_d      = fill_q;
    rx_ready    = (rx_state_q == RX_COLLECT) ? 1'b1 : bus.hsdom_din_ready_i;
    rx_xfer     = bus.rx_valid_i & rx_ready;
    din_xfer    = din_valid_q & bus.hsdom_din_ready_i;
    rx_last     = (fill_q == FILL_W'(NI - 1));
    case (rx_state_q)
      RX_COLLECT: begin
        if (rx_xfer) begin
          if (rx_last || bus.rx_flush_i) begin
            // asm register is kept zero beyond the fill point, so padding is implicit
            din_d       = asm_wr;
            din_valid_d = 1'b1;
            fill_d      = '0;
            asm_d       = '0;
            rx_state_d  = RX_HOLD;
          end else begin
            asm_d  = asm_wr;
            fill_d = fill_q + FILL_W'(1);
          end
        end else if (bus.rx_flush_i && (fill_q != '0)) begin
          din_d       = asm_q;
          din_valid_d = 1'b1;
          fill_d      = '0;
          asm_d       = '0;
          rx_state_d  = RX_HOLD;
        end else begin
          rx_state_d = RX_COLLECT;
        end
      end
      RX_HOLD: begin
        if (din_xfer) begin
          if (rx_xfer) begin
            if (NI == 1) begin
              // single-byte words: the new byte is itself a complete word
              din_d       = asm_wr;
              din_valid_d = 1'b1;
            end else begin
              asm_d       = asm_wr;
              fill_d      = FILL_W'(1);
              din_valid_d = 1'b0;
              rx_state_d  = RX_COLLECT;
            end
          end else begin
            din_valid_d = 1'b0;
            rx_state_d  = RX_COLLECT;
          end
        end else begin
          rx_state_d = RX_HOLD;
        end
      end
      default: begin
        rx_state_d  = RX_COLLECT;
        asm_d       = '0;
        din_valid_d = 1'b0;
        fill_d      = '0;
      end
    endcase
  end

  // RX state and data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q  <= RX_COLLECT;
      asm_q       <= '0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      fill_q      <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      asm_q       <= asm_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      fill_q      <= fill_d;
    end
  end

  assign bus.rx_ready_o        = rx_ready;
  assign bus.hsdom_din_o       = din_q;
  assign bus.hsdom_din_valid_o = din_valid_q;
  assign bus.rx_fill_o         = fill_q;

  // ---------------------------------------------------------------- TX path
  tx_state_e             tx_state_q, tx_state_d;
  logic [DOUT_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last;
  logic                  dout_ready;
  logic                  dout_xfer;
  logic                  tx_xfer;
  logic [7:0]            tx_byte;

  // Byte lane selected by the current index
  always_comb begin
    tx_byte = 8'h00;
    for (int k = 0; k < NO; k++) begin
      tx_byte = (idx_q == IDX_W'(k)) ? word_q[8*k +: 8] : tx_byte;
    end
  end

  // TX next state: accept a word when idle or on the final byte, step through its bytes
  always_comb begin
    tx_state_d = tx_state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_last    = (idx_q == IDX_W'(NO - 1));
    dout_ready = (tx_state_q == TX_IDLE) ? 1'b1 : (tx_last & bus.tx_ready_i);
    dout_xfer  = bus.hsdom_dout_valid_i & dout_ready;
    tx_xfer    = tx_valid_q & bus.tx_ready_i;
    case (tx_state_q)
      TX_IDLE: begin
        if (dout_xfer) begin
          word_d     = bus.hsdom_dout_i;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          tx_state_d = TX_SEND;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_SEND: begin
        if (tx_xfer) begin
          if (tx_last) begin
            if (dout_xfer) begin
              // back-to-back word: no bubble on the host side
              word_d     = bus.hsdom_dout_i;
              idx_d      = '0;
              tx_valid_d = 1'b1;
            end else begin
              idx_d      = '0;
              tx_valid_d = 1'b0;
              tx_state_d = TX_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          tx_state_d = TX_SEND;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        idx_d      = '0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // TX state and data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TX_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign bus.hsdom_dout_ready_o = dout_ready;
  assign bus.tx_byte_o          = tx_byte;
  assign bus.tx_valid_o         = tx_valid_q;
endmodule

// File: tb/tb_adam_host_byte_bridge.sv
// Bench for adam_host_byte_bridge: a directed vector table, a mid-operation
// reset sequence, then constrained-random traffic against a queue-based model.
module tb_adam_host_byte_bridge;
  localparam int DW = 32;
  localparam int OW = 32;
  localparam int NI = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adam_host_byte_bridge_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

  adam_host_byte_bridge #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rxv;
    logic [7:0]  rxb;
    logic        fl;
    logic        dr;
    logic        dv;
    logic [31:0] dw;
    logic        tr;
    logic        e_rrdy;
    logic        e_drdy;
    int          e_fill;
    logic        e_dval;
    logic [31:0] e_din;
    logic        e_tval;
    logic [7:0]  e_tb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic rxv, input logic [7:0] rxb, input logic fl,
                              input logic dr, input logic dv, input logic [31:0] dw,
                              input logic tr, input logic e_rrdy, input logic e_drdy,
                              input int e_fill, input logic e_dval, input logic [31:0] e_din,
                              input logic e_tval, input logic [7:0] e_tb);
    vec_t v;
    v.rxv = rxv; v.rxb = rxb; v.fl = fl; v.dr = dr; v.dv = dv; v.dw = dw; v.tr = tr;
    v.e_rrdy = e_rrdy; v.e_drdy = e_drdy; v.e_fill = e_fill; v.e_dval = e_dval;
    v.e_din = e_din; v.e_tval = e_tval; v.e_tb = e_tb;
    tbl.push_back(v);
  endfunction

  task automatic idle_inputs();
    bus.rx_byte_i          = 8'h00;
    bus.rx_valid_i         = 1'b0;
    bus.rx_flush_i         = 1'b0;
    bus.hsdom_din_ready_i  = 1'b0;
    bus.hsdom_dout_i       = 32'h0;
    bus.hsdom_dout_valid_i = 1'b0;
    bus.tx_ready_i         = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rx_ready"}, 64'(bus.rx_ready_o), 64'd1);
    chk({tag, "_din"}, 64'(bus.hsdom_din_o), 64'd0);
    chk({tag, "_din_valid"}, 64'(bus.hsdom_din_valid_o), 64'd0);
    chk({tag, "_fill"}, 64'(bus.rx_fill_o), 64'd0);
    chk({tag, "_dout_ready"}, 64'(bus.hsdom_dout_ready_o), 64'd1);
    chk({tag, "_tx_byte"}, 64'(bus.tx_byte_o), 64'd0);
    chk({tag, "_tx_valid"}, 64'(bus.tx_valid_o), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // random-phase model state
  logic [7:0]    pq[$];   // bytes collected toward the next word
  logic [DW-1:0] wq[$];   // words emitted but not yet taken by ADAM
  logic [7:0]    tq[$];   // bytes still owed to the host
  logic          rx_x_prev   = 1'b0;
  logic          dout_x_prev = 1'b0;

  initial begin
    idle_inputs();

    // columns: rxv rxb fl dr dv dw tr | rx_rdy dout_rdy fill din_val din tx_val tx_byte
    add(1, 8'h11, 0, 1, 0, 32'h0, 0,  1, 1, 1, 0, 32'h0,        0, 8'h00);
    add(1, 8'h22, 0, 1, 0, 32'h0, 0,  1, 1, 2, 0, 32'h0,        0, 8'h00);
    add(1, 8'h33, 0, 1, 0, 32'h0, 0,  1, 1, 3, 0, 32'h0,        0, 8'h00);
    add(1, 8'h44, 0, 1, 0, 32'h0, 0,  1, 1, 0, 1, 32'h44332211, 0, 8'h00);
    add(0, 8'h00, 0, 1, 0, 32'h0, 0,  1, 1, 0, 0, 32'h44332211, 0, 8'h00);
    // backpressure
    add(1, 8'h01, 0, 0, 0, 32'h0, 0,  1, 1, 1, 0, 32'h44332211, 0, 8'h00);
    add(1, 8'h02, 0, 0, 0, 32'h0, 0,  1, 1, 2, 0, 32'h44332211, 0, 8'h00);
    add(1, 8'h03, 0, 0, 0, 32'h0, 0,  1, 1, 3, 0, 32'h44332211, 0, 8'h00);
    add(1, 8'h04, 0, 0, 0, 32'h0, 0,  1, 1, 0, 1, 32'h04030201, 0, 8'h00);
    add(1, 8'hAA, 0, 0, 0, 32'h0, 0,  0, 1, 0, 1, 32'h04030201, 0, 8'h00);
    add(1, 8'hAA, 0, 1, 0, 32'h0, 0,  1, 1, 1, 0, 32'h04030201, 0, 8'h00);
    add(1, 8'hBB, 0, 1, 0, 32'h0, 0,  1, 1, 2, 0, 32'h04030201, 0, 8'h00);
    add(1, 8'hCC, 0, 1, 0, 32'h0, 0,  1, 1, 3, 0, 32'h04030201, 0, 8'h00);
    add(1, 8'hDD, 0, 1, 0, 32'h0, 0,  1, 1, 0, 1, 32'hDDCCBBAA, 0, 8'h00);
    add(0, 8'h00, 0, 1, 0, 32'h0, 0,  1, 1, 0, 0, 32'hDDCCBBAA, 0, 8'h00);
    // flush
    add(1, 8'hDE, 0, 1, 0, 32'h0, 0,  1, 1, 1, 0, 32'hDDCCBBAA, 0, 8'h00);
    add(1, 8'hAD, 0, 1, 0, 32'h0, 0,  1, 1, 2, 0, 32'hDDCCBBAA, 0, 8'h00);
    add(0, 8'h00, 1, 1, 0, 32'h0, 0,  1, 1, 0, 1, 32'h0000ADDE, 0, 8'h00);
    add(0, 8'h00, 0, 1, 0, 32'h0, 0,  1, 1, 0, 0, 32'h0000ADDE, 0, 8'h00);
    add(0, 8'h00, 1, 1, 0, 32'h0, 0,  1, 1, 0, 0, 32'h0000ADDE, 0, 8'h00);
    add(1, 8'h5A, 1, 1, 0, 32'h0, 0,  1, 1, 0, 1, 32'h0000005A, 0, 8'h00);
    add(0, 8'h00, 0, 1, 0, 32'h0, 0,  1, 1, 0, 0, 32'h0000005A, 0, 8'h00);
    // TX back-to-back words
    add(0, 8'h00, 0, 1, 1, 32'hCAFEBABE, 1,  1, 1, 0, 0, 32'h0000005A, 1, 8'hBE);
    add(0, 8'h00, 0, 1, 1, 32'h12345678, 1,  1, 0, 0, 0, 32'h0000005A, 1, 8'hBA);
    add(0, 8'h00, 0, 1, 1, 32'h12345678, 1,  1, 0, 0, 0, 32'h0000005A, 1, 8'hFE);
    add(0, 8'h00, 0, 1, 1, 32'h12345678, 1,  1, 0, 0, 0, 32'h0000005A, 1, 8'hCA);
    add(0, 8'h00, 0, 1, 1, 32'h12345678, 1,  1, 1, 0, 0, 32'h0000005A, 1, 8'h78);
    add(0, 8'h00, 0, 1, 0, 32'h0,        1,  1, 0, 0, 0, 32'h0000005A, 1, 8'h56);
    add(0, 8'h00, 0, 1, 0, 32'h0,        1,  1, 0, 0, 0, 32'h0000005A, 1, 8'h34);
    add(0, 8'h00, 0, 1, 0, 32'h0,        1,  1, 0, 0, 0, 32'h0000005A, 1, 8'h12);
    add(0, 8'h00, 0, 1, 0, 32'h0,        1,  1, 1, 0, 0, 32'h0000005A, 0, 8'h00);
    // TX stall
    add(0, 8'h00, 0, 1, 1, 32'hAABBCCDD, 0,  1, 1, 0, 0, 32'h0000005A, 1, 8'hDD);
    add(0, 8'h00, 0, 1, 0, 32'h0,        0,  1, 0, 0, 0, 32'h0000005A, 1, 8'hDD);
    add(0, 8'h00, 0, 1, 0, 32'h0,        1,  1, 0, 0, 0, 32'h0000005A, 1, 8'hCC);

    do_reset();

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus.rx_valid_i         = tbl[i].rxv;
      bus.rx_byte_i          = tbl[i].rxb;
      bus.rx_flush_i         = tbl[i].fl;
      bus.hsdom_din_ready_i  = tbl[i].dr;
      bus.hsdom_dout_valid_i = tbl[i].dv;
      bus.hsdom_dout_i       = tbl[i].dw;
      bus.tx_ready_i         = tbl[i].tr;
      #1;
      chk($sformatf("v%0d_rx_ready", i), 64'(bus.rx_ready_o), 64'(tbl[i].e_rrdy));
      chk($sformatf("v%0d_dout_ready", i), 64'(bus.hsdom_dout_ready_o), 64'(tbl[i].e_drdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fill", i), 64'(bus.rx_fill_o), 64'(tbl[i].e_fill));
      chk($sformatf("v%0d_din_valid", i), 64'(bus.hsdom_din_valid_o), 64'(tbl[i].e_dval));
      chk($sformatf("v%0d_din", i), 64'(bus.hsdom_din_o), 64'(tbl[i].e_din));
      chk($sformatf("v%0d_tx_valid", i), 64'(bus.tx_valid_o), 64'(tbl[i].e_tval));
      if (tbl[i].e_tval) begin
        chk($sformatf("v%0d_tx_byte", i), 64'(bus.tx_byte_o), 64'(tbl[i].e_tb));
      end
    end

    // reset with two RX bytes collected and two TX bytes (BB, AA) still owed
    @(negedge clk);
    idle_inputs();
    bus.rx_valid_i = 1'b1; bus.rx_byte_i = 8'h01; bus.tx_ready_i = 1'b1;
    @(negedge clk);
    bus.rx_byte_i = 8'h02; bus.tx_ready_i = 1'b0;
    @(negedge clk);
    idle_inputs();
    chk("pre_rst_fill", 64'(bus.rx_fill_o), 64'd2);
    chk("pre_rst_tx_byte", 64'(bus.tx_byte_o), 64'hBB);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.tx_ready_i = 1'b1;
    bus.hsdom_din_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_tx_valid", 64'(bus.tx_valid_o), 64'd0);
      chk("post_rst_din_valid", 64'(bus.hsdom_din_valid_o), 64'd0);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.rx_valid_i = 1'b1;
      bus.rx_byte_i  = 8'((b + 1) * 16);
    end
    @(posedge clk);
    #1;
    chk("post_rst_word_valid", 64'(bus.hsdom_din_valid_o), 64'd1);
    chk("post_rst_word", 64'(bus.hsdom_din_o), 64'h40302010);

    // randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic held, rx_x, din_x, dout_x, tx_x;
      logic [DW-1:0] w;
      @(negedge clk);
      if (!bus.rx_valid_i || rx_x_prev) begin
        bus.rx_valid_i = ($urandom_range(0, 3) != 0);
        bus.rx_byte_i  = 8'($urandom);
      end
      bus.rx_flush_i        = !bus.rx_flush_i && ($urandom_range(0, 9) == 0);
      bus.hsdom_din_ready_i = ($urandom_range(0, 9) < 7);
      if (!bus.hsdom_dout_valid_i || dout_x_prev) begin
        bus.hsdom_dout_valid_i = ($urandom_range(0, 2) == 0);
        bus.hsdom_dout_i       = $urandom;
      end
      bus.tx_ready_i = ($urandom_range(0, 9) < 6);
      #1;
      held = (wq.size() != 0);
      chk("rnd_rx_ready", 64'(bus.rx_ready_o), 64'(!held || bus.hsdom_din_ready_i));
      chk("rnd_fill", 64'(bus.rx_fill_o), 64'(pq.size()));
      chk("rnd_din_valid", 64'(bus.hsdom_din_valid_o), 64'(held));
      chk("rnd_dout_ready", 64'(bus.hsdom_dout_ready_o),
          64'((tq.size() == 0) || (tq.size() == 1 && bus.tx_ready_i)));
      chk("rnd_tx_valid", 64'(bus.tx_valid_o), 64'(tq.size() != 0));
      if (tq.size() != 0) begin
        chk("rnd_tx_byte", 64'(bus.tx_byte_o), 64'(tq[0]));
      end
      rx_x   = bus.rx_valid_i & bus.rx_ready_o;
      din_x  = bus.hsdom_din_valid_o & bus.hsdom_din_ready_i;
      dout_x = bus.hsdom_dout_valid_i & bus.hsdom_dout_ready_o;
      tx_x   = bus.tx_valid_o & bus.tx_ready_i;
      if (din_x && held) begin
        chk("rnd_din_word", 64'(bus.hsdom_din_o), 64'(wq[0]));
        void'(wq.pop_front());
      end
      if (rx_x) pq.push_back(bus.rx_byte_i);
      if (!held && (pq.size() == NI || (bus.rx_flush_i && pq.size() > 0))) begin
        w = '0;
        for (int k = 0; k < pq.size(); k++) w[8*k +: 8] = pq[k];
        wq.push_back(w);
        pq.delete();
      end
      if (tx_x && tq.size() != 0) void'(tq.pop_front());
      if (dout_x) begin
        for (int k = 0; k < OW / 8; k++) tq.push_back(bus.hsdom_dout_i[8*k +: 8]);
      end
      rx_x_prev   = rx_x;
      dout_x_prev = dout_x;
      @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
